// File: rtl/score_keeper.sv
// Rhythm-game score engine: start-button synchroniser, IDLE/PLAY/OVER state machine,
// saturating score/combo/miss counters and a registered score-change pulse.
module score_keeper #(
  parameter int MAX_SCORE    = 31,
  parameter int COMBO_THRESH = 4,
  parameter int MISS_LIMIT   = 7
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start_btn,
  input  logic       hit,
  input  logic       miss,
  output logic [4:0] score,
  output logic [3:0] combo,
  output logic [2:0] misses,
  output logic       playing,
  output logic       game_over,
  output logic       win,
  output logic       score_chg
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam logic [5:0] MAX6   = 6'(MAX_SCORE);
  localparam logic [4:0] MAX5   = 5'(MAX_SCORE);
  localparam logic [3:0] THRESH = 4'(COMBO_THRESH);
  localparam logic [2:0] LIMIT  = 3'(MISS_LIMIT);

  state_t     state, state_nxt;
  logic [4:0] score_nxt;
  logic [3:0] combo_nxt;
  logic [2:0] misses_nxt;
  logic       win_nxt;
  logic [5:0] sum;
  logic       sync1, sync2, sync2_d;
  logic       start_evt;

  // NOTE: the button is asynchronous; two flops settle metastability before the edge detector.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= start_btn;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign start_evt = sync2 & ~sync2_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    score_nxt  = score;
    combo_nxt  = combo;
    misses_nxt = misses;
    win_nxt    = win;
    sum        = {1'b0, score} + ((combo >= THRESH) ? 6'd2 : 6'd1);
    case (state)
      IDLE, OVER: begin
        if (start_evt) begin
          state_nxt  = PLAY;
          score_nxt  = '0;
          combo_nxt  = '0;
          misses_nxt = '0;
          win_nxt    = 1'b0;
        end
      end
      PLAY: begin
        // A simultaneous hit and miss counts as a miss only.
        if (miss) begin
          combo_nxt  = '0;
          misses_nxt = misses + 3'd1;
          if (misses_nxt == LIMIT) begin
            state_nxt = OVER;
            win_nxt   = 1'b0;
          end
        end else if (hit) begin
          score_nxt = (sum >= MAX6) ? MAX5 : sum[4:0];
          combo_nxt = (combo == 4'd15) ? 4'd15 : combo + 4'd1;
          if (score_nxt == MAX5) begin
            state_nxt = OVER;
            win_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      score     <= '0;
      combo     <= '0;
      misses    <= '0;
      win       <= 1'b0;
      score_chg <= 1'b0;
    end else begin
      state     <= state_nxt;
      score     <= score_nxt;
      combo     <= combo_nxt;
      misses    <= misses_nxt;
      win       <= win_nxt;
      score_chg <= (score_nxt != score);
    end
  end

  assign playing   = (state == PLAY);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus queues hand-computed expected outputs
// tagged with the cycle they are due; a monitor compares them on the falling edge.
module tb_score_keeper;

  typedef struct packed {
    logic [4:0] score;
    logic [3:0] combo;
    logic [2:0] misses;
    logic       playing;
    logic       game_over;
    logic       win;
    logic       score_chg;
  } outs_t;

  typedef struct {
    int    due;
    outs_t o;
    string tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start_btn = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic [4:0] score;
  logic [3:0] combo;
  logic [2:0] misses;
  logic       playing, game_over, win, score_chg;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  score_keeper dut (
    .clk(clk), .nrst(nrst), .start_btn(start_btn), .hit(hit), .miss(miss),
    .score(score), .combo(combo), .misses(misses), .playing(playing),
    .game_over(game_over), .win(win), .score_chg(score_chg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic outs_t mk(int s, int c, int m, bit p, bit ov, bit w, bit ch);
    outs_t r;
    r.score = 5'(s); r.combo = 4'(c); r.misses = 3'(m);
    r.playing = p; r.game_over = ov; r.win = w; r.score_chg = ch;
    return r;
  endfunction

  function automatic outs_t actual();
    return mk(int'(score), int'(combo), int'(misses), playing, game_over, win, score_chg);
  endfunction

  task automatic check(input string tag, input outs_t act, input outs_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got score=%0d combo=%0d misses=%0d play=%b over=%b win=%b chg=%b, expected score=%0d combo=%0d misses=%0d play=%b over=%b win=%b chg=%b",
               tag, act.score, act.combo, act.misses, act.playing, act.game_over, act.win, act.score_chg,
               e.score, e.combo, e.misses, e.playing, e.game_over, e.win, e.score_chg);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected right after the next edge.
  task automatic step(input bit b, input bit h, input bit m, input outs_t e, input string tag);
    exp_t x;
    @(negedge clk);
    start_btn = b; hit = h; miss = m;
    x.due = cyc + 1; x.o = e; x.tag = tag;
    exp_q.push_back(x);
  endtask

  // Monitor: compare every entry that falls due; anything overdue is a missed comparison.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        exp_t x;
        x = exp_q.pop_front();
        if (x.due < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: comparison overdue (due cycle %0d, now %0d)", x.tag, x.due, cyc);
        end else begin
          check(x.tag, actual(), x.o);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check("reset_state", actual(), mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    nrst = 1'b1;

    // Start: button sampled at edge k, event after k+1, PLAY at k+2
    step(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0), "start_k");
    step(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0), "start_k1");
    step(1, 0, 0, mk(0, 0, 0, 1, 0, 0, 0), "start_k2");

    // Six hits, threshold 4: 1,2,3,4,6,8
    step(0, 1, 0, mk(1, 1, 0, 1, 0, 0, 1), "hit1");
    step(0, 1, 0, mk(2, 2, 0, 1, 0, 0, 1), "hit2");
    step(0, 1, 0, mk(3, 3, 0, 1, 0, 0, 1), "hit3");
    step(0, 1, 0, mk(4, 4, 0, 1, 0, 0, 1), "hit4");
    step(0, 1, 0, mk(6, 5, 0, 1, 0, 0, 1), "hit5_combo");
    step(0, 1, 0, mk(8, 6, 0, 1, 0, 0, 1), "hit6_combo");
    step(0, 0, 0, mk(8, 6, 0, 1, 0, 0, 0), "idle_no_chg");

    // Miss breaks the combo; next hit scores 1; hit+miss counts as a miss
    step(0, 0, 1, mk(8, 0, 1, 1, 0, 0, 0), "miss_breaks_combo");
    step(0, 1, 0, mk(9, 1, 1, 1, 0, 0, 1), "hit_after_miss");
    step(0, 1, 1, mk(9, 0, 2, 1, 0, 0, 0), "hit_and_miss");
    step(0, 0, 0, mk(9, 0, 2, 1, 0, 0, 0), "hold_9");

    // Asynchronous reset in the middle of a cycle
    @(negedge clk);
    #2 nrst = 1'b0;
    #1 check("async_reset_midgame", actual(), mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    nrst = 1'b1;

    // Button held for 20 cycles: one start; lose by 7 misses while still held
    step(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0), "hold_k");
    step(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0), "hold_k1");
    step(1, 0, 0, mk(0, 0, 0, 1, 0, 0, 0), "hold_k2_play");
    for (int i = 1; i <= 6; i++)
      step(1, 0, 1, mk(0, 0, i, 1, 0, 0, 0), $sformatf("miss_%0d", i));
    step(1, 0, 1, mk(0, 0, 7, 0, 1, 0, 0), "miss_7_loss");
    for (int i = 0; i < 10; i++)
      step(1, i[0], ~i[0], mk(0, 0, 7, 0, 1, 0, 0), $sformatf("held_over_%0d", i));

    // Release, then restart from OVER
    step(0, 0, 0, mk(0, 0, 7, 0, 1, 0, 0), "release_a");
    step(0, 0, 0, mk(0, 0, 7, 0, 1, 0, 0), "release_b");
    step(0, 0, 0, mk(0, 0, 7, 0, 1, 0, 0), "release_c");
    step(1, 0, 0, mk(0, 0, 7, 0, 1, 0, 0), "restart_k");
    step(1, 0, 0, mk(0, 0, 7, 0, 1, 0, 0), "restart_k1");
    step(1, 0, 0, mk(0, 0, 0, 1, 0, 0, 0), "restart_clears");
    step(0, 0, 0, mk(0, 0, 0, 1, 0, 0, 0), "restart_idle");

    // Climb to 30 with combo saturating at 15, then saturate score at 31 and win
    for (int n = 1; n <= 17; n++) begin
      int s;
      s = (n <= 4) ? n : 4 + 2 * (n - 4);
      step(0, 1, 0, mk(s, (n > 15) ? 15 : n, 0, 1, 0, 0, 1), $sformatf("climb_%0d", n));
    end
    step(0, 1, 0, mk(31, 15, 0, 0, 1, 1, 1), "saturate_win");
    step(0, 1, 0, mk(31, 15, 0, 0, 1, 1, 0), "hit_ignored_over");
    step(0, 0, 1, mk(31, 15, 0, 0, 1, 1, 0), "miss_ignored_over");

    // Restart after a win clears score, combo and win
    step(1, 0, 0, mk(31, 15, 0, 0, 1, 1, 0), "rewin_k");
    step(1, 0, 0, mk(31, 15, 0, 0, 1, 1, 0), "rewin_k1");
    step(1, 0, 0, mk(0, 0, 0, 1, 0, 0, 1), "rewin_clears");
    step(0, 0, 0, mk(0, 0, 0, 1, 0, 0, 0), "rewin_idle");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
